salu_result_arbiter: RTL and testbench

// - Downstream of the per-op salu_compute units; merges their result streams into the single SGPR writeback port.
// - NUM_UNITS valid/ready inputs carry salu_issued_instr_t results, with wr_req.val already filled in.
// - Round-robin arbitration feeds a 2-entry output FIFO, which registers the path to writeback.
// - Each transfer moves one beat; the arbiter never drops, duplicates or reorders beats from the same unit.

---
 rtl/salu_result_arbiter.sv | 104 ++++++++++
 tb/tb_salu_result_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/salu_result_arbiter.sv
// Merges NUM_UNITS salu_compute result streams into one SGPR writeback port:
// round-robin arbitration into a 2-entry FIFO that registers the writeback path.
module salu_result_arbiter #(
    parameter int NUM_UNITS = 2,
    parameter int INSTR_W   = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_UNITS-1:0]           in_valid,
    output logic [NUM_UNITS-1:0]           in_ready,
    input  logic [NUM_UNITS*INSTR_W-1:0]   in_data,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [INSTR_W-1:0]             wr_data,
    output logic [$clog2(NUM_UNITS):0]     grant_idx
);

    localparam int IDX_W = $clog2(NUM_UNITS) + 1;
    typedef logic [IDX_W-1:0] idx_t;

    idx_t               rr_ptr;
    idx_t               win_idx;
    logic               win_found;
    logic [INSTR_W-1:0] win_data;

    logic [1:0]         count;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [INSTR_W-1:0] fifo_mem [2];

    logic               can_push;
    logic               push;
    logic               pop;

    // Two-pass scan: units at or above rr_ptr first, then wrap to unit 0.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!win_found && in_valid[i] && (idx_t'(i) >= rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = idx_t'(i);
                win_data  = in_data[i*INSTR_W +: INSTR_W];
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!win_found && in_valid[i]) begin
                win_found = 1'b1;
                win_idx   = idx_t'(i);
                win_data  = in_data[i*INSTR_W +: INSTR_W];
            end
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign can_push = rst_n && ((count != 2'd2) || wr_ready);
    assign push     = win_found && can_push;
    assign pop      = wr_valid && wr_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            in_ready[i] = push && (win_idx == idx_t'(i));
        end
    end

    assign grant_idx = win_idx;
    assign wr_valid  = (count != 2'd0);
    assign wr_data   = fifo_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (win_idx == idx_t'(NUM_UNITS - 1)) ? '0 : win_idx + idx_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= win_data;
    end

endmodule

// File: tb/tb_salu_result_arbiter.sv
// Self-checking bench for salu_result_arbiter (NUM_UNITS=4): a spec-level
// model with a data scoreboard runs every cycle, plus table and hand sequences.
module tb_salu_result_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int GW = $clog2(N) + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [W-1:0]   wr_data;
    logic [GW-1:0]  grant_idx;

    always #5 clk = ~clk;

    salu_result_arbiter #(.NUM_UNITS(N), .INSTR_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .grant_idx (grant_idx)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        logic [N-1:0] exp_ready;
        int           exp_grant;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb[$];
    int           m_rr = 0;

    logic [N-1:0]  obs_ready;
    logic [GW-1:0] obs_grant;
    logic          obs_wv;
    logic [W-1:0]  obs_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_unit(input int u, input logic [W-1:0] d);
        in_data[u*W +: W] = d;
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge.
    task automatic cycle();
        logic         found;
        int           win;
        logic         acc;
        logic         popm;
        logic [N-1:0] expr;
        logic [W-1:0] d;
        @(negedge clk);
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        acc  = found && ((sb.size() < 2) || wr_ready);
        expr = acc ? (N'(1) << win) : '0;
        obs_ready = in_ready;
        obs_grant = grant_idx;
        obs_wv    = wr_valid;
        obs_wd    = wr_data;
        check("in_ready", in_ready, expr);
        if (acc) check("grant_idx", grant_idx, win);
        check("wr_valid", wr_valid, sb.size() != 0);
        if (sb.size() != 0) check("wr_data", wr_data, sb[0]);
        popm = (sb.size() != 0) && wr_ready;
        d    = in_data[win*W +: W];
        @(posedge clk);
        if (popm) void'(sb.pop_front());
        if (acc) begin
            sb.push_back(d);
            m_rr = (win + 1) % N;
        end
        #1;
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases it on a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("wr_valid_async_rst", wr_valid, 1'b0);
        check("in_ready_in_rst", in_ready, '0);
        sb.delete();
        m_rr = 0;
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] t2_vals[3];
        int           transfers;
        logic         got3;

        tbl[0] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b0001, exp_grant: 0};
        tbl[1] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b0010, exp_grant: 1};
        tbl[2] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b0100, exp_grant: 2};
        tbl[3] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b1000, exp_grant: 3};
        tbl[4] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b0001, exp_grant: 0};
        tbl[5] = '{valid: 4'b1111, rdy: 1'b1, exp_ready: 4'b0010, exp_grant: 1};
        t2_vals = '{32'h11, 32'h22, 32'h33};

        // Reset state with every unit requesting.
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        wr_ready = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, '0);
        check("rst_wr_valid", wr_valid, 1'b0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: fill to count 2, stall, then reset mid-stream.
        in_valid = 4'b0001; set_unit(0, 32'h100); cycle();
        in_valid = 4'b0010; set_unit(1, 32'h101); cycle();
        in_valid = 4'b1111; cycle();
        check("t1_full_stall", obs_ready, '0);
        check("t1_full_valid", obs_wv, 1'b1);
        do_reset();
        in_valid = 4'b0011; wr_ready = 1'b1;
        set_unit(0, 32'hA0); set_unit(1, 32'hB0);
        cycle();
        check("t1_first_grant", obs_grant, 0);
        check("t1_empty_after_rst", obs_wv, 1'b0);
        in_valid = '0;
        cycle();

        // Test 2: unit 1 streams back-to-back; beats appear one cycle later, no bubbles.
        do_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_valid = 4'b0010;
                set_unit(1, t2_vals[i]);
            end else begin
                in_valid = '0;
            end
            cycle();
            if (i > 0) begin
                check("t2_wr_valid", obs_wv, 1'b1);
                check("t2_wr_data", obs_wd, t2_vals[i-1]);
            end
        end
        cycle();
        check("t2_drained", obs_wv, 1'b0);

        // Test 3: round-robin with everyone requesting.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            in_valid = tbl[r].valid;
            wr_ready = tbl[r].rdy;
            for (int u = 0; u < N; u++) set_unit(u, 32'hC000 + r*16 + u);
            cycle();
            check("t3_ready", obs_ready, tbl[r].exp_ready);
            check("t3_grant", obs_grant, tbl[r].exp_grant);
        end
        in_valid = '0;
        repeat (3) cycle();

        // Test 4: backpressure holds two beats and ignores stalled data.
        do_reset();
        wr_ready = 1'b0;
        in_valid = 4'b0011; set_unit(0, 32'hA); set_unit(1, 32'hB);
        cycle();
        in_valid = 4'b0010;
        cycle();
        check("t4_second_accept", obs_ready, 4'b0010);
        in_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            set_unit(0, 32'hDEAD0000 + i);
            set_unit(1, 32'hBEEF0000 + i);
            cycle();
            check("t4_stalled", obs_ready, '0);
        end
        in_valid = '0; wr_ready = 1'b1;
        cycle();
        check("t4_pop_a", obs_wd, 32'hA);
        cycle();
        check("t4_pop_b", obs_wd, 32'hB);
        cycle();
        check("t4_empty", obs_wv, 1'b0);

        // Test 5: full FIFO pops and pushes in the same cycle.
        do_reset();
        wr_ready = 1'b0;
        in_valid = 4'b0001; set_unit(0, 32'h50); cycle();
        in_valid = 4'b0010; set_unit(1, 32'h51); cycle();
        wr_ready = 1'b1;
        in_valid = 4'b0100; set_unit(2, 32'hC);
        cycle();
        check("t5_accept_c", obs_ready, 4'b0100);
        check("t5_head", obs_wd, 32'h50);
        in_valid = '0;
        cycle();
        check("t5_second", obs_wd, 32'h51);
        cycle();
        check("t5_c_third", obs_wd, 32'hC);
        cycle();
        check("t5_empty", obs_wv, 1'b0);

        // Test 6: unit 3 joins a busy unit 0 and must be served promptly.
        do_reset();
        wr_ready = 1'b1;
        in_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            set_unit(0, 32'h600 + c);
            cycle();
        end
        in_valid = 4'b1001;
        set_unit(3, 32'h6333);
        transfers = 0;
        got3      = 1'b0;
        for (int i = 0; i < 8 && !got3; i++) begin
            cycle();
            if (obs_ready != '0) transfers++;
            if (obs_ready[3]) got3 = 1'b1;
        end
        check("t6_unit3_granted", got3, 1'b1);
        check("t6_within_4", transfers <= 4, 1'b1);
        cycle();
        check("t6_rr_back_to_0", obs_grant, 0);
        in_valid = '0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
